eigen_deflation: RTL
====================

Name: eigen_deflation

Overview:
- Downstream consumer of the Rayleigh-quotient eigenvalue stage.
- Takes the converged eigenvector v, its eigenvalue lambda and the covariance matrix A, and produces the deflated matrix A' = A - lambda*v*v^T.
- A' feeds the next power-iteration / eigencalculation pass to extract the next principal component.
- Time-multiplexes one registered double multiplier and one registered double subtractor.

Parameters:
- SIZE_N, 8, matrix dimension; vector length. Legal range 2..16.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  level request; operation launched on sampled rising edge (low->high)
- timed_matrix  in  double[SIZE_N][SIZE_N]  input matrix A, captured at launch
- vector  in  double[SIZE_N][1]  eigenvector v, captured at launch
- eigenvalue  in  double (64)  lambda, captured at launch
- deflated_matrix  out  double[SIZE_N][SIZE_N]  result A'
- busy  out  1  high while in SCALE or DEFLATE
- f  out  1  finished flag

Behaviour:
- Reset (synchronous, active-high, overrides everything):
  - state=IDLE; f=0; busy=0; deflated_matrix all +0.0 (64'h0).
  - Internal captures, scale vector s[] and pipeline registers are cleared.
- Arithmetic:
  - IEEE-754 binary64, round-to-nearest-even via the fp_double primitives.
  - NaN/Inf propagate per the primitives; no special-casing.
- FSM: IDLE -> SCALE -> DEFLATE -> DONE.
  - IDLE: on start=1 with start_q=0 (rising edge), latch A, v and lambda, clear f, go to SCALE. Edge E0.
  - SCALE: one element per cycle, i=0..SIZE_N-1: s[i] <= lambda*v[i]. Lasts SIZE_N cycles, then DEFLATE.
  - DEFLATE: row-major element index k=(i,j), 2-stage pipeline.
    - Stage 1: p <= s[i]*v[j].
    - Stage 2: deflated_matrix[i][j] <= A[i][j] - p.
    - Lasts SIZE_N*SIZE_N+1 cycles (fill + drain), then DONE.
  - DONE: f=1, busy=0. Hold f and deflated_matrix while start=1. On start=0, clear f and go to IDLE.
- Latency: f first high SIZE_N*SIZE_N+SIZE_N+2 rising edges after E0 (N=2: 8; N=8: 74).
- Outputs:
  - deflated_matrix elements update only when written in DEFLATE, and hold otherwise.
  - The matrix is valid only while f=1.
- Abort: start=0 during SCALE or DEFLATE returns to IDLE next edge.
  - f stays 0.
  - deflated_matrix keeps any elements already written; contents are not valid.
- Start held high:
  - After DONE, no relaunch until start goes low then high again.
  - start high in IDLE without a rising edge (for example, high out of reset) does not launch.
- Input changes after E0 are ignored: captured copies are used.
- Reset asserted mid-operation: the reset values above apply on that edge, with no partial writes.

Optional Feature:
- Macro DEFLATE_SYMM_EN.
- Defined:
  - DEFLATE iterates only the upper triangle j>=i, SIZE_N*(SIZE_N+1)/2 elements.
  - Each result is written to both [i][j] and [j][i].
  - DEFLATE lasts SIZE_N*(SIZE_N+1)/2+1 cycles; latency to f is SIZE_N*(SIZE_N+1)/2+SIZE_N+2 (N=2: 7).
  - The lower triangle of timed_matrix is ignored; A must be symmetric.
- Undefined: full SIZE_N*SIZE_N sweep as above; no symmetry assumption.

Test Plan (SIZE_N=2 unless stated):
- Basic deflation: A=[[4,1],[1,3]], v=[1,0], lambda=4, start rising -> f=1 at 8th edge; deflated_matrix=[[0,1],[1,3]] exactly; busy high 7 cycles.
- Fractional values: A=[[1,0],[0,1]], v=[0.5,0.5], lambda=2 -> [[0.5,-0.5],[-0.5,0.5]] exactly. Then drop start -> f=0 next edge; raise start again -> same result recomputed.
- Abort: launch case 1, drop start at cycle 4 -> IDLE, f never asserted. Relaunch with case 2 -> correct case-2 result at edge 8.
- Reset mid-op: assert rst at cycle 5 of case 1 -> next edge f=0, busy=0, all deflated_matrix=64'h0; no launch while start stays high after rst releases.
- Input isolation and N=8: change timed_matrix/vector/eigenvalue every cycle after E0 -> result matches launch-time inputs. With SIZE_N=8, A=identity, v=e0, lambda=1 -> A' = diag(0,1,1,1,1,1,1,1); f at edge 74.
- DEFLATE_SYMM_EN defined: case 1 -> f at edge 7; same result; the [1][0] write coincides with the [0][1] write.

Source files
------------

// File: rtl/eigen_deflation.sv
// ---------------------------------------------------------------------------
// eigen_deflation
//
// Removes one converged principal component from a covariance matrix:
//   A' = A - lambda * v * v^T
// The result feeds the next power-iteration pass.
//
// Datapath: one registered binary64 multiplier and one registered binary64
// subtractor, time-multiplexed over the whole operation.
//   SCALE   : s[i] = lambda * v[i]              (SIZE_N cycles)
//   DEFLATE : p = s[i] * v[j]; A'[i][j] = A[i][j] - p
//             (2-stage pipeline, row-major, element count + 1 cycles)
//
// Ports:
//   clk             in   clock, all state on rising edge
//   rst             in   synchronous active-high reset
//   start           in   level request, launch on sampled low->high
//   timed_matrix    in   A, SIZE_N x SIZE_N binary64, captured at launch
//   vector          in   v, SIZE_N binary64, captured at launch
//   eigenvalue      in   lambda, binary64, captured at launch
//   deflated_matrix out  A', valid only while f = 1
//   busy            out  high in SCALE or DEFLATE
//   f               out  finished flag, held while start stays high
//
// Build option:
//   DEFLATE_SYMM_EN  sweep only the upper triangle (j >= i) and mirror each
//                    result into [j][i]; A is then assumed symmetric.
// ---------------------------------------------------------------------------
module eigen_deflation #(
  parameter int SIZE_N = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [SIZE_N-1:0][SIZE_N-1:0][63:0] timed_matrix,
  input  logic [SIZE_N-1:0][63:0]             vector,
  input  logic [63:0]                         eigenvalue,
  output logic [SIZE_N-1:0][SIZE_N-1:0][63:0] deflated_matrix,
  output logic                                busy,
  output logic                                f
);

  localparam int IW = (SIZE_N > 1) ? $clog2(SIZE_N) : 1;
`ifdef DEFLATE_SYMM_EN
  localparam int NELEM = SIZE_N * (SIZE_N + 1) / 2;
`else
  localparam int NELEM = SIZE_N * SIZE_N;
`endif
  localparam logic [8:0]    SCALE_LAST = 9'(SIZE_N - 1);
  // DEFLATE runs NELEM + 1 cycles, so its last count value equals NELEM.
  localparam logic [8:0]    ELEM_CNT   = 9'(NELEM);
  localparam logic [IW-1:0] IDX_LAST   = IW'(SIZE_N - 1);
  localparam logic [63:0]   QNAN       = 64'h7FF8_0000_0000_0000;

  typedef enum logic [1:0] {IDLE, SCALE, DEFLATE, DONE} state_t;

  state_t                              state, state_d;
  logic                                start_q;
  logic [SIZE_N-1:0][SIZE_N-1:0][63:0] a_q;
  logic [SIZE_N-1:0][63:0]             v_q, s_q;
  logic [63:0]                         lam_q, p_q;
  logic [8:0]                          cnt;
  logic [IW-1:0]                       i1, j1, i2, j2;
  logic [63:0]                         mul_a, mul_b, mul_y, sub_y;

  // ---------------- binary64 helpers (round to nearest even) --------------
  function automatic logic is_nan(input logic [63:0] x);
    return (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
  endfunction

  function automatic logic is_inf(input logic [63:0] x);
    return (x[62:52] == 11'h7FF) && (x[51:0] == 52'd0);
  endfunction

  function automatic int msb_pos(input logic [105:0] x);
    int p;
    p = -1;
    for (int k = 0; k < 106; k++) begin
      if (x[k]) p = k;
    end
    return p;
  endfunction

  // Right shift that ORs every bit shifted out into bit 0 (sticky).
  function automatic logic [105:0] shr_sticky(input logic [105:0] x, input int amt);
    logic [105:0] r;
    if (amt <= 0) return x;
    if (amt >= 106) return {105'd0, |x};
    r = x >> amt;
    r[0] = r[0] | (|(x & ~({106{1'b1}} << amt)));
    return r;
  endfunction

  function automatic logic [63:0] fp_mul(input logic [63:0] a, input logic [63:0] b);
    logic         sgn, up;
    int           ea, eb, e, p;
    logic [105:0] prod;
    logic [53:0]  m;
    sgn = a[63] ^ b[63];
    if (is_nan(a) || is_nan(b)) return QNAN;
    if (is_inf(a) || is_inf(b)) begin
      if (a[62:0] == 63'd0 || b[62:0] == 63'd0) return QNAN;
      return {sgn, 11'h7FF, 52'd0};
    end
    if (a[62:0] == 63'd0 || b[62:0] == 63'd0) return {sgn, 63'd0};
    ea   = (a[62:52] == 11'd0) ? 1 : int'(a[62:52]);
    eb   = (b[62:52] == 11'd0) ? 1 : int'(b[62:52]);
    prod = {53'd0, (a[62:52] != 11'd0), a[51:0]} * {53'd0, (b[62:52] != 11'd0), b[51:0]};
    // Normalise so the leading one sits at bit 105.
    p    = msb_pos(prod);
    prod = prod << (105 - p);
    e    = ea + eb - 1023 + p - 104;
    // Too small for a normal: denormalise, keeping lost bits as sticky.
    if (e < 1) begin
      prod = shr_sticky(prod, 1 - e);
      e    = 0;
    end
    up = prod[52] && ((|prod[51:0]) || prod[53]);
    m  = {1'b0, prod[105:53]} + {53'd0, up};
    if (m[53]) begin
      m = m >> 1;
      e = e + 1;
    end
    // A denormal that rounded up into the hidden bit becomes the smallest normal.
    if (e == 0 && m[52]) e = 1;
    if (e >= 2047) return {sgn, 11'h7FF, 52'd0};
    return {sgn, e[10:0], m[51:0]};
  endfunction

  function automatic logic [63:0] fp_add(input logic [63:0] a, input logic [63:0] b);
    logic [63:0]  x, y;
    logic         sub, up;
    int           ex, ey, e, p, sh;
    logic [105:0] mx, my, r;
    logic [53:0]  m;
    if (is_nan(a) || is_nan(b)) return QNAN;
    if (is_inf(a) && is_inf(b)) return (a[63] != b[63]) ? QNAN : a;
    if (is_inf(a)) return a;
    if (is_inf(b)) return b;
    // x carries the larger magnitude and therefore the result sign.
    if (a[62:0] >= b[62:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    sub = x[63] ^ y[63];
    ex  = (x[62:52] == 11'd0) ? 1 : int'(x[62:52]);
    ey  = (y[62:52] == 11'd0) ? 1 : int'(y[62:52]);
    // Hidden bit at 55, three guard/round/sticky bits below the mantissa.
    mx  = {50'd0, (x[62:52] != 11'd0), x[51:0], 3'b000};
    my  = shr_sticky({50'd0, (y[62:52] != 11'd0), y[51:0], 3'b000}, ex - ey);
    r   = sub ? (mx - my) : (mx + my);
    // Exact cancellation gives +0; two equal-signed zeros keep their sign.
    if (r == 106'd0) return sub ? 64'd0 : {x[63], 63'd0};
    p = msb_pos(r);
    e = ex;
    if (p == 56) begin
      r = shr_sticky(r, 1);
      e = e + 1;
    end else if (p < 55) begin
      sh = 55 - p;
      if (sh > e - 1) sh = e - 1;
      r = r << sh;
      e = e - sh;
    end
    up = r[2] && ((|r[1:0]) || r[3]);
    m  = r[56:3] + {53'd0, up};
    if (m[53]) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e == 1 && !m[52]) e = 0;
    if (e >= 2047) return {x[63], 11'h7FF, 52'd0};
    return {x[63], e[10:0], m[51:0]};
  endfunction

  // The single multiplier scales lambda*v[i] in SCALE and forms s[i]*v[j]
  // in DEFLATE; the single subtractor always works on the stage-2 element.
  always_comb begin
    mul_a = s_q[i1];
    mul_b = v_q[j1];
    if (state == SCALE) begin
      mul_a = lam_q;
      mul_b = v_q[cnt[IW-1:0]];
    end
  end

  assign mul_y = fp_mul(mul_a, mul_b);
  assign sub_y = fp_add(a_q[i2][j2], {~p_q[63], p_q[62:0]});

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state logic; dropping start while working aborts back to IDLE.
  always_comb begin
    state_d = state;
    busy    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !start_q) state_d = SCALE;
      end
      SCALE: begin
        busy = 1'b1;
        if (!start)                 state_d = IDLE;
        else if (cnt == SCALE_LAST) state_d = DEFLATE;
      end
      DEFLATE: begin
        busy = 1'b1;
        if (!start)               state_d = IDLE;
        else if (cnt == ELEM_CNT) state_d = DONE;
      end
      DONE: begin
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand capture, scale vector, two-stage deflate pipeline and
  // the finished flag. start_q resets high so a start already high when
  // reset releases is not mistaken for a rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_q         <= 1'b1;
      f               <= 1'b0;
      a_q             <= '0;
      v_q             <= '0;
      s_q             <= '0;
      lam_q           <= '0;
      p_q             <= '0;
      cnt             <= '0;
      i1              <= '0;
      j1              <= '0;
      i2              <= '0;
      j2              <= '0;
      deflated_matrix <= '0;
    end else begin
      start_q <= start;
      case (state)
        IDLE: begin
          if (start && !start_q) begin
            a_q   <= timed_matrix;
            v_q   <= vector;
            lam_q <= eigenvalue;
            f     <= 1'b0;
            cnt   <= '0;
          end
        end
        SCALE: begin
          s_q[cnt[IW-1:0]] <= mul_y;
          cnt              <= (cnt == SCALE_LAST) ? 9'd0 : cnt + 9'd1;
          i1               <= '0;
          j1               <= '0;
        end
        DEFLATE: begin
          cnt <= cnt + 9'd1;
          if (cnt < ELEM_CNT) begin
            p_q <= mul_y;
            i2  <= i1;
            j2  <= j1;
            if (j1 == IDX_LAST) begin
              i1 <= i1 + 1'b1;
`ifdef DEFLATE_SYMM_EN
              j1 <= i1 + 1'b1;
`else
              j1 <= '0;
`endif
            end else begin
              j1 <= j1 + 1'b1;
            end
          end
          // Stage 2 lags stage 1 by one cycle, so count 0 has nothing to write.
          if (cnt != 9'd0) begin
            deflated_matrix[i2][j2] <= sub_y;
`ifdef DEFLATE_SYMM_EN
            deflated_matrix[j2][i2] <= sub_y;
`endif
          end
        end
        DONE: begin
          f <= start;
        end
        default: ;
      endcase
    end
  end

endmodule
